// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e   : FSM encoding (IDLE / BUSY / DONE)
//   cnt_width : bit-counter width for a given operand width (never below 1)
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit combinational full subtractor: x - y - bin.
//   i_w_x    : minuend bit
//   i_w_y    : subtrahend bit
//   i_w_bin  : borrow in
//   o_w_d    : difference bit
//   o_w_bout : borrow out
module full_subtractor (
  input  logic i_w_x,
  input  logic i_w_y,
  input  logic i_w_bin,
  output logic o_w_d,
  output logic o_w_bout
);

  assign o_w_d    = i_w_x ^ i_w_y ^ i_w_bin;
  assign o_w_bout = (~i_w_x & i_w_y) | (~(i_w_x ^ i_w_y) & i_w_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B, one bit per clock, LSB first.
// Operands are accepted on a valid/ready handshake in IDLE, p_width BUSY cycles
// produce the difference, and the result is offered in DONE until taken.
//   i_w_clk, i_w_reset     : clock, asynchronous active-high reset
//   i_w_a, i_w_b           : unsigned operands
//   i_w_valid / o_w_ready  : operand handshake (ready only in IDLE)
//   o_w_d                  : (p_width+1)-bit two's-complement difference
//   o_w_borrow             : final borrow (A < B), equal to o_w_d MSB
//   o_w_valid / i_w_ready  : result handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int p_width = 6
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic [p_width-1:0] i_w_a,
  input  logic [p_width-1:0] i_w_b,
  input  logic               i_w_valid,
  output logic               o_w_ready,
  output logic [p_width:0]   o_w_d,
  output logic               o_w_borrow,
  output logic               o_w_valid,
  input  logic               i_w_ready
);

  localparam int              CW       = cnt_width(p_width);
  localparam logic [CW-1:0]   CNT_LAST = CW'(p_width - 1);

  state_e               state_q, state_d;
  logic [p_width-1:0]   a_q, a_d;
  logic [p_width-1:0]   b_q, b_d;
  logic [p_width-1:0]   diff_q, diff_d;
  logic                 brw_q, brw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [p_width:0]     res_q, res_d;
  logic                 bout_q, bout_d;

  logic                 d_bit;
  logic                 brw_nxt;
  logic [p_width-1:0]   diff_shift;

  full_subtractor u_fs (
    .i_w_x    (a_q[0]),
    .i_w_y    (b_q[0]),
    .i_w_bin  (brw_q),
    .o_w_d    (d_bit),
    .o_w_bout (brw_nxt)
  );

  // New difference bit enters from the MSB side; after p_width shifts the
  // LSB-first stream sits in natural bit order.
  assign diff_shift = p_width'({d_bit, diff_q} >> 1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bout_d  = bout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_w_valid) begin
          a_d     = i_w_a;
          b_d     = i_w_b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = diff_shift;
        brw_d  = brw_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Final borrow is the sign bit of the widened result.
          res_d   = {brw_nxt, diff_shift};
          bout_d  = brw_nxt;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_w_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
    end
  end

  // Handshake flags decode straight from the state register, so o_w_valid
  // never sees i_w_ready combinationally.
  assign o_w_ready  = (state_q == ST_IDLE);
  assign o_w_valid  = (state_q == ST_DONE);
  assign o_w_d      = res_q;
  assign o_w_borrow = bout_q;

endmodule
